// File: rtl/cam_cfg_sequencer_pkg.sv
// Shared types and sensor constants for the camera register-table sequencer.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    FETCH    = 3'd1,
    ISSUE    = 3'd2,
    WAIT     = 3'd3,
    POST_DLY = 3'd4,
    NEXT     = 3'd5,
    DONE     = 3'd6,
    ERR      = 3'd7
  } cfg_state_t;

  localparam logic [7:0]  SENSOR_RST_ADDR = 8'h12;
  localparam int unsigned SENSOR_RST_BIT  = 32'd7;
  localparam logic [7:0]  BANK_SEL_ADDR   = 8'hFF;

  // A write to the common-control register with the reset bit set restarts the sensor.
  function automatic logic is_sensor_reset(input logic [7:0] addr, input logic [7:0] data);
    return (addr == SENSOR_RST_ADDR) && data[SENSOR_RST_BIT];
  endfunction

endpackage

// File: rtl/cam_cfg_sequencer_if.sv
// Write-request handshake between the configuration sequencer and the SCCB master.
interface cam_cfg_sequencer_if;

  logic       sccb_req;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_done;
  logic       sccb_nack;

  modport master (
    output sccb_req,
    output sccb_addr,
    output sccb_data,
    input  sccb_done,
    input  sccb_nack
  );

  modport slave (
    input  sccb_req,
    input  sccb_addr,
    input  sccb_data,
    output sccb_done,
    output sccb_nack
  );

endinterface

// File: rtl/cam_cfg_sequencer_timer.sv
// Shared settling-delay counter: cleared while idle, counts while enabled, flags when it hits limit.
module cfg_delay_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_r;

  // Counter restarts from zero on every entry into a delay state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + WIDTH'(32'd1);
    end
  end

  assign expired = (cnt_r == limit);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the camera register table issuing one SCCB write per entry, with power-up and soft-reset settling.
// Optional NACK retry per entry is built when CFG_RETRY_EN is defined.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int REG_NUM     = 179,
  parameter int POWERUP_DLY = 50000,
  parameter int RESET_DLY   = 250000
`ifdef CFG_RETRY_EN
  ,
  parameter int MAX_RETRY   = 3
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [7:0]                 rom_addr,
  input  logic [15:0]                rom_data,
  cam_cfg_sequencer_if.master        sccb,
  output logic                       cfg_busy,
  output logic                       cfg_done,
  output logic                       cfg_err
);

  localparam int DLY_MAX = (POWERUP_DLY > RESET_DLY) ? POWERUP_DLY : RESET_DLY;
  localparam int DLY_W   = ($clog2(DLY_MAX) < 1) ? 1 : $clog2(DLY_MAX);
  localparam logic [DLY_W-1:0] PWR_LIM  = DLY_W'(POWERUP_DLY - 32'sd1);
  localparam logic [DLY_W-1:0] RST_LIM  = DLY_W'(RESET_DLY - 32'sd1);
  localparam logic [7:0]       LAST_IDX = 8'(REG_NUM - 32'sd1);

`ifdef CFG_RETRY_EN
  localparam int RTY_W = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
  logic [RTY_W-1:0] retry_r;
`endif

  cfg_state_t       state_r;
  logic             tmr_clr_s;
  logic [DLY_W-1:0] tmr_limit_s;
  logic             tmr_expired_s;

  // Only the two delay states let the timer run; every other state holds it at zero.
  always_comb begin
    tmr_clr_s   = 1'b1;
    tmr_limit_s = PWR_LIM;
    case (state_r)
      PWR_WAIT: begin
        tmr_clr_s   = 1'b0;
        tmr_limit_s = PWR_LIM;
      end
      POST_DLY: begin
        tmr_clr_s   = 1'b0;
        tmr_limit_s = RST_LIM;
      end
      default: begin
        tmr_clr_s   = 1'b1;
        tmr_limit_s = PWR_LIM;
      end
    endcase
  end

  cfg_delay_timer #(.WIDTH(DLY_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr_s),
    .limit   (tmr_limit_s),
    .expired (tmr_expired_s)
  );

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= PWR_WAIT;
      rom_addr       <= 8'd0;
      sccb.sccb_req  <= 1'b0;
      sccb.sccb_addr <= 8'd0;
      sccb.sccb_data <= 8'd0;
      cfg_busy       <= 1'b1;
      cfg_done       <= 1'b0;
      cfg_err        <= 1'b0;
`ifdef CFG_RETRY_EN
      retry_r        <= '0;
`endif
    end else begin
      case (state_r)
        PWR_WAIT: begin
          if (tmr_expired_s) state_r <= FETCH;
        end
        FETCH: begin
          sccb.sccb_addr <= rom_data[15:8];
          sccb.sccb_data <= rom_data[7:0];
          state_r        <= ISSUE;
        end
        ISSUE: begin
          sccb.sccb_req <= 1'b1;
          state_r       <= WAIT;
        end
        WAIT: begin
          if (sccb.sccb_done) begin
            sccb.sccb_req <= 1'b0;
            if (!sccb.sccb_nack) begin
              if (is_sensor_reset(sccb.sccb_addr, sccb.sccb_data)) state_r <= POST_DLY;
              else state_r <= NEXT;
            end else begin
`ifdef CFG_RETRY_EN
              if (retry_r < RTY_MAX) begin
                retry_r <= retry_r + RTY_W'(32'd1);
                state_r <= ISSUE;
              end else begin
                state_r  <= ERR;
                cfg_err  <= 1'b1;
                cfg_busy <= 1'b0;
              end
`else
              state_r  <= ERR;
              cfg_err  <= 1'b1;
              cfg_busy <= 1'b0;
`endif
            end
          end
        end
        POST_DLY: begin
          if (tmr_expired_s) state_r <= NEXT;
        end
        NEXT: begin
          if (rom_addr == LAST_IDX) begin
            state_r  <= DONE;
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
          end else begin
            rom_addr <= rom_addr + 8'd1;
            state_r  <= FETCH;
`ifdef CFG_RETRY_EN
            retry_r  <= '0;
`endif
          end
        end
        DONE, ERR: begin
          sccb.sccb_req <= 1'b0;
          if (start) begin
            state_r  <= PWR_WAIT;
            rom_addr <= 8'd0;
            cfg_busy <= 1'b1;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
`ifdef CFG_RETRY_EN
            retry_r  <= '0;
`endif
          end
        end
        default: begin
          state_r       <= ERR;
          sccb.sccb_req <= 1'b0;
          cfg_busy      <= 1'b0;
          cfg_done      <= 1'b0;
          cfg_err       <= 1'b1;
        end
      endcase
    end
  end

endmodule
